// File: rtl/rca_adder.sv
// Registered ripple-carry adder: WIDTH chained full adders feeding one output
// register stage with valid tracking and a two's-complement overflow flag.
module rca_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic             ovf_comb;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        rca_full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .c  (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    // For WIDTH = 1 carry[WIDTH-1] is carry[0], i.e. cin itself.
    assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_comb;
                cout <= carry[WIDTH];
                ovf  <= ovf_comb;
            end
        end
    end

endmodule

// Single-bit full adder used as the ripple cell.
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));

endmodule

// File: tb/tb_rca_adder.sv
// Directed and exhaustive checks of rca_adder at WIDTH=4, plus random vectors at WIDTH=8.
module tb_rca_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a4, b4, sum4;
    logic       cin4, cout4, ovf4, out_valid4;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8, ovf8, out_valid8;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rca_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4),
        .out_valid (out_valid4)
    );

    rca_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8),
        .out_valid (out_valid8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic test_reset_initial();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        #3;
        tests_run++;
        if ({sum4, cout4, ovf4, out_valid4} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_initial: got sum=%0h cout=%b ovf=%b v=%b, want all 0",
                     sum4, cout4, ovf4, out_valid4);
        end
        tests_run++;
        if ({sum8, cout8, ovf8, out_valid8} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_initial_w8: got sum=%0h cout=%b ovf=%b v=%b, want all 0",
                     sum8, cout8, ovf8, out_valid8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t vecs[8];
        vecs = '{
            '{4'd0,  4'd0, 1'b0, 4'd0,  1'b0, 1'b0},
            '{4'd1,  4'd1, 1'b0, 4'd2,  1'b0, 1'b0},
            '{4'd3,  4'd3, 1'b1, 4'd7,  1'b0, 1'b0},
            '{4'd15, 4'd0, 1'b1, 4'd0,  1'b1, 1'b0},
            '{4'd10, 4'd5, 1'b1, 4'd0,  1'b1, 1'b0},
            '{4'd7,  4'd8, 1'b0, 4'd15, 1'b0, 1'b0},
            '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1},
            '{4'd8,  4'd8, 1'b0, 4'd0,  1'b1, 1'b1}
        };
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a4 = vecs[i].a; b4 = vecs[i].b; cin4 = vecs[i].cin;
            @(negedge clk);
            in_valid = 1'b0;
            tests_run++;
            if ({sum4, cout4, ovf4, out_valid4} !== {vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b1}) begin
                tests_failed++;
                $display("FAIL directed[%0d] %0d+%0d+%0d: got sum=%0d cout=%b ovf=%b v=%b, want sum=%0d cout=%b ovf=%b v=1",
                         i, vecs[i].a, vecs[i].b, vecs[i].cin, sum4, cout4, ovf4, out_valid4,
                         vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            end
        end
    endtask

    task automatic test_valid_gating();
        @(negedge clk);
        in_valid = 1'b1;
        a4 = 4'd1; b4 = 4'd1; cin4 = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({sum4, out_valid4} !== {4'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL gating_load: got sum=%0d v=%b, want sum=2 v=1", sum4, out_valid4);
        end
        in_valid = 1'b0;
        a4 = 4'd15; b4 = 4'd15;
        @(negedge clk);
        tests_run++;
        if ({sum4, cout4, ovf4, out_valid4} !== {4'd2, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL gating_hold: got sum=%0d cout=%b ovf=%b v=%b, want sum=2 cout=0 ovf=0 v=0",
                     sum4, cout4, ovf4, out_valid4);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        in_valid = 1'b1;
        a4 = 4'd5; b4 = 4'd6; cin4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if ({sum4, out_valid4} !== {4'd12, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_preload: got sum=%0d v=%b, want sum=12 v=1", sum4, out_valid4);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({sum4, cout4, ovf4, out_valid4} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got sum=%0d cout=%b ovf=%b v=%b, want all 0",
                     sum4, cout4, ovf4, out_valid4);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        a4 = 4'd2; b4 = 4'd3; cin4 = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if ({sum4, cout4, out_valid4} !== {4'd5, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_first_capture: got sum=%0d cout=%b v=%b, want sum=5 cout=0 v=1",
                     sum4, cout4, out_valid4);
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [4:0] exp_total;
        logic       exp_ovf;
        logic [8:0] idx;
        int         sa, sb, st;
        bit         have_prev = 1'b0;
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (have_prev) begin
                tests_run++;
                if ({cout4, sum4, ovf4, out_valid4} !== {exp_total, exp_ovf, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL exhaustive_w4 %0d+%0d+%0d: got cout=%b sum=%0d ovf=%b v=%b, want cout=%b sum=%0d ovf=%b v=1",
                             a4, b4, cin4, cout4, sum4, ovf4, out_valid4,
                             exp_total[4], exp_total[3:0], exp_ovf);
                end
            end
            if (i < 512) begin
                idx      = 9'(i);
                in_valid = 1'b1;
                a4 = idx[3:0]; b4 = idx[7:4]; cin4 = idx[8];
                exp_total = 5'(int'(a4) + int'(b4) + int'(cin4));
                sa = (a4 >= 4'd8) ? int'(a4) - 16 : int'(a4);
                sb = (b4 >= 4'd8) ? int'(b4) - 16 : int'(b4);
                st = sa + sb + int'(cin4);
                exp_ovf   = (st > 7) || (st < -8);
                have_prev = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_random_w8();
        logic [8:0] exp_total;
        logic       exp_ovf;
        int         sa, sb, st;
        bit         have_prev = 1'b0;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (have_prev) begin
                tests_run++;
                if ({cout8, sum8, ovf8, out_valid8} !== {exp_total, exp_ovf, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL random_w8 %0d+%0d+%0d: got cout=%b sum=%0d ovf=%b v=%b, want cout=%b sum=%0d ovf=%b v=1",
                             a8, b8, cin8, cout8, sum8, ovf8, out_valid8,
                             exp_total[8], exp_total[7:0], exp_ovf);
                end
            end
            if (i < 300) begin
                in_valid = 1'b1;
                if (i == 0) begin
                    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
                end else begin
                    a8   = 8'($urandom_range(0, 255));
                    b8   = 8'($urandom_range(0, 255));
                    cin8 = 1'($urandom_range(0, 1));
                end
                exp_total = 9'(int'(a8) + int'(b8) + int'(cin8));
                sa = (a8 >= 8'd128) ? int'(a8) - 256 : int'(a8);
                sb = (b8 >= 8'd128) ? int'(b8) - 256 : int'(b8);
                st = sa + sb + int'(cin8);
                exp_ovf   = (st > 127) || (st < -128);
                have_prev = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset_initial();
        test_directed();
        test_valid_gating();
        test_reset_midstream();
        test_exhaustive_w4();
        test_random_w8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
